bus_dma_host: RTL and testbench

Memory-mapped word-copy DMA engine for the simple system bus, the initiator-side counterpart of the bus devices. A register port sits on the bus as a device, alongside RAM, SimCtrl and Timer. A host port attaches as a second bus host (`NrHosts` = 2) and performs word-by-word copies from a source region to a destination region. An interrupt line reports completion to the core.

---
 rtl/bus_dma_host_if.sv | 23 ++
 rtl/bus_dma_host.sv | 191 +++++++++++++++++++
 tb/tb_bus_dma_host.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dma_host_if.sv
// Simple system bus channel: request/grant handshake followed by a one-cycle response.
// The master side issues requests; the slave side grants and responds.
interface bus_dma_host_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/bus_dma_host.sv
// Word-copy DMA engine: a memory-mapped register port plus a bus host port that
// copies LEN words from SRC to DST, one outstanding bus transaction at a time.
module bus_dma_host #(
  parameter int LenWidth = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_dma_host_if.slave  dma,
  bus_dma_host_if.master host,
  output logic           dma_irq
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t              state_reg;
  logic [31:0]         src_reg;
  logic [31:0]         dst_reg;
  logic [LenWidth-1:0] len_reg;
  logic                ie_reg;
  logic                done_reg;
  logic                err_reg;
  logic                rvalid_reg;
  logic                rerr_reg;
  logic [31:0]         rdata_reg;
  logic                req_reg;
  logic                we_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         wdata_reg;

  logic [9:0]          off;
  logic                off_ok;
  logic                reg_wr;
  logic                ctrl_wr;
  logic                busy;
  logic [31:0]         src_wr;
  logic [31:0]         dst_wr;
  logic [LenWidth-1:0] len_wr;
  logic [31:0]         rd_val;
  logic                unused_addr;

  assign off         = dma.addr[9:0];
  assign off_ok      = (off == 10'h0) || (off == 10'h4) || (off == 10'h8) || (off == 10'hC);
  assign reg_wr      = dma.req && dma.we && off_ok;
  assign ctrl_wr     = reg_wr && (off == 10'hC) && dma.be[0];
  assign busy        = (state_reg != IDLE);
  assign unused_addr = ^dma.addr[31:10];

  // Byte-enable merge of write data into the current register values.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_addr_merge
      if (gi < 2) begin : g_low
        assign src_wr[gi] = 1'b0;
        assign dst_wr[gi] = 1'b0;
      end else begin : g_high
        assign src_wr[gi] = dma.be[gi >> 3] ? dma.wdata[gi] : src_reg[gi];
        assign dst_wr[gi] = dma.be[gi >> 3] ? dma.wdata[gi] : dst_reg[gi];
      end
    end
    for (gi = 0; gi < LenWidth; gi++) begin : g_len_merge
      assign len_wr[gi] = dma.be[gi >> 3] ? dma.wdata[gi] : len_reg[gi];
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (off)
      10'h0:   rd_val = src_reg;
      10'h4:   rd_val = dst_reg;
      10'h8:   rd_val = 32'(len_reg);
      10'hC:   rd_val = {28'd0, err_reg, done_reg, ie_reg, busy};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      ie_reg     <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
      rerr_reg   <= 1'b0;
      rdata_reg  <= '0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      rvalid_reg <= dma.req;
      rerr_reg   <= dma.req && !off_ok;
      rdata_reg  <= (dma.req && !dma.we) ? rd_val : '0;

      if (reg_wr && !busy) begin
        if (off == 10'h0) src_reg <= src_wr;
        if (off == 10'h4) dst_reg <= dst_wr;
        if (off == 10'h8) len_reg <= len_wr;
      end
      if (ctrl_wr) begin
        ie_reg <= dma.wdata[1];
        if (dma.wdata[2]) begin
          done_reg <= 1'b0;
          err_reg  <= 1'b0;
        end
      end

      // FSM updates come last so a completion beats a same-cycle DONE_CLR.
      case (state_reg)
        IDLE: begin
          if (ctrl_wr && dma.wdata[0]) begin
            err_reg <= 1'b0;
            if (len_reg == '0) begin
              done_reg <= 1'b1;
            end else begin
              done_reg  <= 1'b0;
              state_reg <= RD_REQ;
              req_reg   <= 1'b1;
              we_reg    <= 1'b0;
              addr_reg  <= src_reg;
            end
          end
        end
        RD_REQ: begin
          if (host.gnt) begin
            state_reg <= RD_WAIT;
            req_reg   <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (host.rvalid) begin
            if (host.err) begin
              state_reg <= IDLE;
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
            end else begin
              wdata_reg <= host.rdata;
              state_reg <= WR_REQ;
              req_reg   <= 1'b1;
              we_reg    <= 1'b1;
              addr_reg  <= dst_reg;
            end
          end
        end
        WR_REQ: begin
          if (host.gnt) begin
            state_reg <= WR_WAIT;
            req_reg   <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (host.rvalid) begin
            if (host.err) begin
              state_reg <= IDLE;
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
            end else begin
              src_reg <= src_reg + 32'd4;
              dst_reg <= dst_reg + 32'd4;
              len_reg <= len_reg - LenWidth'(1);
              if (len_reg == LenWidth'(1)) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= RD_REQ;
                req_reg   <= 1'b1;
                we_reg    <= 1'b0;
                addr_reg  <= src_reg + 32'd4;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dma.gnt    = 1'b1;
  assign dma.rvalid = rvalid_reg;
  assign dma.rdata  = rdata_reg;
  assign dma.err    = rerr_reg;

  assign host.req   = req_reg;
  assign host.we    = we_reg;
  assign host.be    = 4'hF;
  assign host.addr  = addr_reg;
  assign host.wdata = wdata_reg;

  assign dma_irq = done_reg & ie_reg;
endmodule

// File: tb/tb_bus_dma_host.sv
// Bench for bus_dma_host: register-port vector table, directed corner sequences,
// and randomized copies checked against a word-level copy model with a bus memory.
module tb_bus_dma_host;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dma_irq;

  bus_dma_host_if dma_bus();
  bus_dma_host_if host_bus();

  bus_dma_host #(.LenWidth(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dma     (dma_bus),
    .host    (host_bus),
    .dma_irq (dma_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vec_q[$];
  int total = 0;
  int bad = 0;

  // Bus memory and responder state.
  logic [31:0] mem [logic [31:0]];
  int stall_cnt = 0;
  bit stall_rand = 0;
  int err_rd_at = 0;
  int err_wr_at = 0;
  int n_rd = 0;
  int n_wr = 0;
  int req_cycles = 0;
  int stab_bad = 0;
  bit pend = 0;
  logic [31:0] pend_rdata = '0;
  logic pend_err = 1'b0;
  bit held = 0;
  logic [31:0] held_addr, held_wdata;
  logic held_we;
  logic [31:0] src_vals[$];
  logic [31:0] dst_old[$];

  initial begin
    host_bus.gnt = 1'b0;
    host_bus.rvalid = 1'b0;
    host_bus.rdata = '0;
    host_bus.err = 1'b0;
    forever begin
      @(negedge clk);
      host_bus.rvalid = pend;
      host_bus.rdata = pend_rdata;
      host_bus.err = pend_err;
      pend = 0;
      host_bus.gnt = 1'b0;
      if (!rst_n) begin
        held = 0;
      end else if (host_bus.req) begin
        req_cycles++;
        if (held && (host_bus.addr !== held_addr || host_bus.we !== held_we || host_bus.wdata !== held_wdata))
          stab_bad++;
        if (stall_cnt > 0 || (stall_rand && $urandom_range(0, 2) == 0)) begin
          if (stall_cnt > 0) stall_cnt--;
          held = 1;
          held_addr = host_bus.addr;
          held_we = host_bus.we;
          held_wdata = host_bus.wdata;
        end else begin
          held = 0;
          host_bus.gnt = 1'b1;
          pend = 1;
          pend_rdata = '0;
          pend_err = 1'b0;
          if (host_bus.we) begin
            n_wr++;
            if (n_wr == err_wr_at) pend_err = 1'b1;
            else mem[host_bus.addr] = host_bus.wdata;
          end else begin
            n_rd++;
            pend_rdata = mem.exists(host_bus.addr) ? mem[host_bus.addr] : 32'hBAD0BAD0;
            if (n_rd == err_rd_at) pend_err = 1'b1;
          end
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic addv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vec_q.push_back(v);
  endtask

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output logic rvalid);
    dma_bus.req = 1'b1; dma_bus.we = we; dma_bus.addr = addr;
    dma_bus.wdata = wdata; dma_bus.be = be;
    @(negedge clk);
    dma_bus.req = 1'b0; dma_bus.we = 1'b0;
    rdata = dma_bus.rdata; err = dma_bus.err; rvalid = dma_bus.rvalid;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e, v;
    acc(1'b0, addr, 32'd0, 4'hF, data, e, v);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic e, v;
    acc(1'b1, addr, data, 4'hF, d, e, v);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] c;
    for (int i = 0; i < 400; i++) begin
      rd(32'hC, c);
      if (!c[0]) return;
    end
    total++; bad++;
    $display("FAIL %s idle: BUSY still 1 after 400 polls, want 0", name);
  endtask

  task automatic prep(input logic [31:0] s, input logic [31:0] d, input int len, input bit fixed);
    src_vals.delete();
    dst_old.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] v, o;
      v = fixed ? 32'(17 * (i + 1)) : $urandom();
      o = $urandom();
      mem[s + 32'(4 * i)] = v;
      mem[d + 32'(4 * i)] = o;
      src_vals.push_back(v);
      dst_old.push_back(o);
    end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int len, input bit ie);
    n_rd = 0; n_wr = 0; req_cycles = 0; stab_bad = 0;
    wr(32'h0, s);
    wr(32'h4, d);
    wr(32'h8, 32'(len));
    wr(32'hC, {30'd0, ie, 1'b1});
  endtask

  // Word-level model: an error on word k leaves k-1 words copied and the
  // counters pointing at word k; a failed write is counted but not stored.
  task automatic check_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int len, input bit ie, input int rd_err, input int wr_err);
    int copied, exp_wr;
    logic eflag;
    logic [31:0] v;
    if (rd_err > 0) begin copied = rd_err - 1; exp_wr = rd_err - 1; eflag = 1'b1; end
    else if (wr_err > 0) begin copied = wr_err - 1; exp_wr = wr_err; eflag = 1'b1; end
    else begin copied = len; exp_wr = len; eflag = 1'b0; end
    rd(32'h0, v); check({name, " SRC"}, v, s + 32'(4 * copied));
    rd(32'h4, v); check({name, " DST"}, v, d + 32'(4 * copied));
    rd(32'h8, v); check({name, " LEN"}, v, 32'(len - copied));
    rd(32'hC, v); check({name, " CTRL"}, v, {28'd0, eflag, 1'b1, ie, 1'b0});
    check({name, " irq"}, 32'(dma_irq), 32'(ie));
    check({name, " writes"}, 32'(n_wr), 32'(exp_wr));
    for (int i = 0; i < len; i++)
      check($sformatf("%s dst[%0d]", name, i), mem[d + 32'(4 * i)], (i < copied) ? src_vals[i] : dst_old[i]);
    $display("copy %s: src=%08h dst=%08h len=%0d ie=%0d rd_err=%0d wr_err=%0d", name, s, d, len, ie, rd_err, wr_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, s, d;
    logic e, rv;
    int first, found, len, sel, rerr, werr;
    bit ie;

    dma_bus.req = 1'b0; dma_bus.we = 1'b0; dma_bus.be = 4'h0;
    dma_bus.addr = '0; dma_bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset host_req", 32'(host_bus.req), 32'd0);
    check("reset host_be", 32'(host_bus.be), 32'hF);
    check("reset host_addr", host_bus.addr, 32'd0);
    check("reset irq", 32'(dma_irq), 32'd0);
    check("reset rvalid", 32'(dma_bus.rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    addv(0, 32'h0,        32'h0,        4'hF, 32'h0,        0);
    addv(0, 32'h4,        32'h0,        4'hF, 32'h0,        0);
    addv(0, 32'h8,        32'h0,        4'hF, 32'h0,        0);
    addv(0, 32'hC,        32'h0,        4'hF, 32'h0,        0);
    addv(1, 32'h0,        32'h12345677, 4'hF, 32'h0,        0);
    addv(0, 32'h0,        32'h0,        4'hF, 32'h12345674, 0);
    addv(1, 32'h4,        32'hAABBCCDD, 4'h5, 32'h0,        0);
    addv(0, 32'h4,        32'h0,        4'hF, 32'h00BB00DC, 0);
    addv(1, 32'h8,        32'hFFFF1234, 4'hF, 32'h0,        0);
    addv(0, 32'h8,        32'h0,        4'hF, 32'h00001234, 0);
    addv(1, 32'h8,        32'h0000AB00, 4'h2, 32'h0,        0);
    addv(0, 32'h8,        32'h0,        4'hF, 32'h0000AB34, 0);
    addv(1, 32'hC,        32'h00000002, 4'hF, 32'h0,        0);
    addv(0, 32'hC,        32'h0,        4'hF, 32'h00000002, 0);
    addv(1, 32'hC,        32'h00000000, 4'hE, 32'h0,        0);
    addv(0, 32'hC,        32'h0,        4'hF, 32'h00000002, 0);
    addv(0, 32'h10,       32'h0,        4'hF, 32'h0,        1);
    addv(1, 32'h14,       32'hFFFFFFFF, 4'hF, 32'h0,        1);
    addv(0, 32'hFFFFF008, 32'h0,        4'hF, 32'h0000AB34, 0);
    addv(0, 32'h3FD,      32'h0,        4'hF, 32'h0,        1);
    addv(1, 32'hC,        32'h0,        4'hF, 32'h0,        0);
    addv(0, 32'hC,        32'h0,        4'hF, 32'h0,        0);
    addv(0, 32'h0,        32'h0,        4'hF, 32'h12345674, 0);
    foreach (vec_q[i]) begin
      acc(vec_q[i].we, vec_q[i].addr, vec_q[i].wdata, vec_q[i].be, v, e, rv);
      check($sformatf("vec%0d rdata", i), v, vec_q[i].exp_rdata);
      check($sformatf("vec%0d err", i), 32'(e), 32'(vec_q[i].exp_err));
      check($sformatf("vec%0d rvalid", i), 32'(rv), 32'd1);
    end

    // Basic copy with interrupt latency.
    prep(32'h100100, 32'h100200, 4, 1);
    start_copy(32'h100100, 32'h100200, 4, 1);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dma_irq && first == 0) first = i;
    end
    check("basic irq latency", 32'(first), 32'd16);
    check_copy("basic", 32'h100100, 32'h100200, 4, 1, 0, 0);

    // Zero length: DONE immediately, no bus traffic.
    start_copy(32'h3000, 32'h4000, 0, 0);
    rd(32'hC, v);
    check("zero CTRL", v, 32'h4);
    repeat (4) @(negedge clk);
    check("zero req cycles", 32'(req_cycles), 32'd0);

    // Grant stall on the first read.
    prep(32'h5000, 32'h6000, 2, 0);
    stall_cnt = 5;
    start_copy(32'h5000, 32'h6000, 2, 0);
    wait_idle("stall");
    check("stall consumed", 32'(stall_cnt), 32'd0);
    check("stall stable", 32'(stab_bad), 32'd0);
    check_copy("stall", 32'h5000, 32'h6000, 2, 0, 0, 0);

    // Read error on the second word.
    prep(32'h7000, 32'h7100, 3, 0);
    err_rd_at = 2;
    start_copy(32'h7000, 32'h7100, 3, 0);
    wait_idle("rderr");
    err_rd_at = 0;
    check_copy("rderr", 32'h7000, 32'h7100, 3, 0, 2, 0);

    // Register writes and START while busy are ignored; bad offset errors.
    prep(32'h8000, 32'h8100, 4, 0);
    start_copy(32'h8000, 32'h8100, 4, 0);
    repeat (5) @(negedge clk);
    wr(32'h0, 32'hDEAD0000);
    wr(32'hC, 32'h1);
    acc(1'b0, 32'h10, 32'h0, 4'hF, v, e, rv);
    check("busy bad offset err", 32'(e), 32'd1);
    check("busy bad offset rdata", v, 32'd0);
    wait_idle("busy");
    check_copy("busy", 32'h8000, 32'h8100, 4, 0, 0, 0);

    // Asynchronous reset while a write request is pending.
    prep(32'h9000, 32'h9100, 3, 1);
    start_copy(32'h9000, 32'h9100, 3, 1);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (host_bus.req && host_bus.we) found = 1;
    end
    check("reset found WR_REQ", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset async req", 32'(host_bus.req), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h0, v); check("post-reset SRC", v, 32'd0);
    rd(32'h4, v); check("post-reset DST", v, 32'd0);
    rd(32'h8, v); check("post-reset LEN", v, 32'd0);
    rd(32'hC, v); check("post-reset CTRL", v, 32'd0);
    check("post-reset irq", 32'(dma_irq), 32'd0);

    // Randomized copies, the first one wrapping past 2^32.
    for (int n = 0; n < 15; n++) begin
      len = $urandom_range(1, 6);
      ie = 1'($urandom_range(0, 1));
      stall_rand = 1'($urandom_range(0, 1));
      if (n == 0) begin
        s = 32'hFFFFFFF8;
        d = 32'h00010000;
      end else begin
        s = 32'h20000000 + 32'(n) * 32'h1000 + ($urandom_range(0, 63) << 2);
        d = s + 32'h800;
      end
      sel = $urandom_range(0, 3);
      rerr = (sel == 0) ? $urandom_range(1, len) : 0;
      werr = (sel == 1) ? $urandom_range(1, len) : 0;
      err_rd_at = rerr;
      err_wr_at = werr;
      prep(s, d, len, 0);
      start_copy(s, d, len, ie);
      wait_idle($sformatf("rand%0d", n));
      err_rd_at = 0;
      err_wr_at = 0;
      stall_rand = 0;
      check_copy($sformatf("rand%0d", n), s, d, len, ie, rerr, werr);
      check($sformatf("rand%0d stable", n), 32'(stab_bad), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
